// File: rtl/sprite_sort_ctrl.sv
// sprite_sort_ctrl: per-scanline OAM scan and sorter scheduler.
// Scans NUM_OAM entries, forwards the first MAX_SPR Y-range hits to the
// sorter, pulses sort_start, waits for sort_done and then flags the list ready.
// Optional macro SORT_TIMEOUT_EN adds a sort watchdog that drives err_out.
module sprite_sort_ctrl #(
    parameter int NUM_OAM     = 40,
    parameter int MAX_SPR     = 10,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_start,
    input  logic [7:0] ly,
    input  logic       tall_spr,
    output logic [5:0] oam_addr,
    input  logic [7:0] oam_y,
    input  logic [7:0] oam_x,
    output logic       sort_wr_en,
    output logic [3:0] sort_wr_idx,
    output logic [7:0] sort_wr_x,
    output logic [5:0] sort_wr_id,
    output logic [3:0] sort_count,
    output logic       sort_start,
    input  logic       sort_done,
    output logic       busy_out,
    output logic       list_valid_out,
    output logic       done_out,
    output logic       drop_out,
    output logic       err_out
);

    localparam logic [5:0] LAST_IDX  = 6'(NUM_OAM - 1);
    localparam logic [3:0] LAST_SLOT = 4'(MAX_SPR - 1);

    // Index and count widths are fixed at 6 and 4 bits; larger sizes are unsupported.
    if (NUM_OAM < 1 || NUM_OAM > 64 || MAX_SPR < 1 || MAX_SPR > 15 || TIMEOUT_CYC < 1) begin : g_bad_params
    end

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, SORT, READY} state_t;

    state_t     state, state_nxt, state_d;
    logic [5:0] idx, idx_d;
    logic       vld_d;
    logic [3:0] count;
    logic [7:0] ly_r;
    logic       tall_r;
    logic       accept;
    logic [8:0] diff;
    logic       hit;
    logic       tmo_hit;

    assign accept = line_start && (state == IDLE || state == READY);

    // Returned entry is a hit when the current line falls inside its Y range;
    // a wrapped (negative) difference becomes a large value and misses.
    assign diff = {1'b0, ly_r} + 9'd16 - {1'b0, oam_y};
    assign hit  = vld_d && (state == SCAN || state == DRAIN) &&
                  (diff < (tall_r ? 9'd16 : 9'd8));

`ifdef SORT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_r;

    assign tmo_hit = (state == SORT) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign err_out = err_r;

    // Watchdog: counts cycles spent in SORT; err sticks until the next accepted line.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_r   <= 1'b0;
        end else begin
            tmo_cnt <= (state == SORT) ? tmo_cnt + 1'b1 : '0;
            if (accept)
                err_r <= 1'b0;
            else if (tmo_hit && count != 4'd0 && !sort_done)
                err_r <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err_out = 1'b0;
`endif

    // Next-state logic; early exit on the MAX_SPR-th hit bypasses DRAIN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN: begin
                if (hit && count == LAST_SLOT)
                    state_nxt = SORT;
                else if (idx == LAST_IDX)
                    state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = SORT;
            SORT: begin
                if (count == 4'd0 || sort_done || tmo_hit)
                    state_nxt = READY;
            end
            READY:   if (accept) state_nxt = SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    // State, scan index, one-cycle address delay line and hit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            state_d <= IDLE;
            idx     <= '0;
            idx_d   <= '0;
            vld_d   <= 1'b0;
            count   <= '0;
            ly_r    <= '0;
            tall_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            state_d <= state;
            idx_d   <= idx;
            vld_d   <= (state == SCAN) && (state_nxt == SCAN || state_nxt == DRAIN);
            if (accept) begin
                ly_r   <= ly;
                tall_r <= tall_spr;
                idx    <= '0;
                count  <= '0;
            end else begin
                if (state == SCAN)
                    idx <= idx + 1'b1;
                if (hit)
                    count <= count + 1'b1;
            end
        end
    end

    // Outputs decoded from state; write fields are zero when no write occurs.
    always_comb begin
        oam_addr       = (state == SCAN) ? idx : 6'd0;
        sort_wr_en     = hit;
        sort_wr_idx    = hit ? count : 4'd0;
        sort_wr_x      = hit ? oam_x : 8'd0;
        sort_wr_id     = hit ? idx_d : 6'd0;
        sort_count     = count;
        sort_start     = (state == SORT) && (state_d != SORT) && (count != 4'd0);
        busy_out       = (state == SCAN) || (state == DRAIN) || (state == SORT);
        list_valid_out = (state == READY);
        done_out       = (state == READY) && (state_d != READY);
        drop_out       = line_start && busy_out;
    end

endmodule

// File: tb/tb_sprite_sort_ctrl.sv
// tb_sprite_sort_ctrl: scoreboard bench for sprite_sort_ctrl with an OAM
// RAM model (1-cycle read) and a sorter model with programmable latency.
module tb_sprite_sort_ctrl;

    localparam int NUM = 40;
    localparam int MAXS = 10;
    localparam int TMO = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       line_start;
    logic [7:0] ly;
    logic       tall_spr;
    logic [5:0] oam_addr;
    logic [7:0] oam_y;
    logic [7:0] oam_x;
    logic       sort_wr_en;
    logic [3:0] sort_wr_idx;
    logic [7:0] sort_wr_x;
    logic [5:0] sort_wr_id;
    logic [3:0] sort_count;
    logic       sort_start;
    logic       sort_done;
    logic       busy_out;
    logic       list_valid_out;
    logic       done_out;
    logic       drop_out;
    logic       err_out;

    always #5 clk = ~clk;

    sprite_sort_ctrl #(.NUM_OAM(NUM), .MAX_SPR(MAXS), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .ly(ly), .tall_spr(tall_spr),
        .oam_addr(oam_addr), .oam_y(oam_y), .oam_x(oam_x),
        .sort_wr_en(sort_wr_en), .sort_wr_idx(sort_wr_idx), .sort_wr_x(sort_wr_x),
        .sort_wr_id(sort_wr_id), .sort_count(sort_count), .sort_start(sort_start),
        .sort_done(sort_done), .busy_out(busy_out), .list_valid_out(list_valid_out),
        .done_out(done_out), .drop_out(drop_out), .err_out(err_out)
    );

    // OAM RAM model, data one cycle after address
    logic [7:0] mem_y [64];
    logic [7:0] mem_x [64];
    always @(posedge clk) begin
        oam_y <= mem_y[oam_addr];
        oam_x <= mem_x[oam_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0] slot;
        logic [7:0] x;
        logic [5:0] id;
    } wr_t;
    wr_t exp_q[$];

    // Sorter model: sort_done pulses sort_lat cycles after sort_start (negative = never)
    int sort_lat = 0;
    int tmr = -1;
    always @(negedge clk) begin
        sort_done = 1'b0;
        if (rst) tmr = -1;
        else begin
            if (sort_start && sort_lat >= 0) tmr = sort_lat;
            if (tmr == 0) begin
                sort_done = 1'b1;
                tmr = -1;
            end else if (tmr > 0) tmr--;
        end
    end

    // Monitor: write scoreboard and event capture
    int n_start, start_cyc, start_cnt, done_cyc, n_drop, max_addr, ls_cyc;
    bit done_seen;
    always @(negedge clk) begin : mon
        wr_t e;
        if (!rst) begin
            if (sort_wr_en) begin
                if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("wr_idx", 32'(sort_wr_idx), 32'(e.slot));
                    chk("wr_x",   32'(sort_wr_x),   32'(e.x));
                    chk("wr_id",  32'(sort_wr_id),  32'(e.id));
                end
            end
            if (sort_start) begin
                n_start++;
                start_cyc = cyc;
                start_cnt = 32'(sort_count);
            end
            if (done_out && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            if (drop_out) n_drop++;
            if (busy_out && 32'(oam_addr) > max_addr) max_addr = 32'(oam_addr);
        end
    end

    task automatic goto(input int c);
        while (1) begin
            @(posedge clk); #1;
            if (cyc >= c) break;
        end
    endtask

    // Build expected writes, then pulse an accepted line_start; returns expected count
    task automatic start_line(input int l, input bit t, input int lat, output int exp_cnt);
        int cnt = 0;
        logic [8:0] d;
        for (int i = 0; i < NUM; i++) begin
            d = 9'(l) + 9'd16 - {1'b0, mem_y[i]};
            if (d < (t ? 9'd16 : 9'd8) && cnt < MAXS) begin
                exp_q.push_back('{slot: 4'(cnt), x: mem_x[i], id: 6'(i)});
                cnt++;
            end
        end
        exp_cnt   = cnt;
        sort_lat  = lat;
        n_start   = 0;
        done_seen = 1'b0;
        n_drop    = 0;
        max_addr  = 0;
        ly = 8'(l);
        tall_spr = t;
        line_start = 1'b1;
        ls_cyc = cyc;
        @(posedge clk); #1;
        line_start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(busy_out), 1);
        chk("valid_cleared", 32'(list_valid_out), 0);
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (!done_seen && k < bound) begin
            @(negedge clk); k++;
        end
        #1;
        chk("done_reached", 32'(done_seen), 1);
    endtask

    task automatic check_line(input int exp_cnt, input int lat, input bit chk_lat);
        chk("sort_count", 32'(sort_count), 32'(exp_cnt));
        chk("list_valid", 32'(list_valid_out), 1);
        chk("busy_idle", 32'(busy_out), 0);
        chk("err", 32'(err_out), 0);
        chk("writes_left", 32'(exp_q.size()), 0);
        chk("n_sort_start", 32'(n_start), (exp_cnt > 0) ? 1 : 0);
        if (exp_cnt > 0) chk("start_count", 32'(start_cnt), 32'(exp_cnt));
        if (chk_lat) chk("latency", 32'(done_cyc - ls_cyc), 32'(43 + ((exp_cnt > 0) ? lat : 0)));
        @(negedge clk);
        chk("done_one_cycle", 32'(done_out), 0);
        chk("valid_held", 32'(list_valid_out), 1);
        exp_q.delete();
    endtask

    task automatic fill(input logic [7:0] y);
        for (int i = 0; i < 64; i++) begin
            mem_y[i] = y;
            mem_x[i] = 8'(i * 3 + 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_valid", 32'(list_valid_out), 0);
        chk("rst_count", 32'(sort_count), 0);
        chk("rst_start", 32'(sort_start), 0);
        chk("rst_done", 32'(done_out), 0);
        chk("rst_err", 32'(err_out), 0);
        chk("rst_wr_en", 32'(sort_wr_en), 0);
        chk("rst_addr", 32'(oam_addr), 0);
        chk("rst_drop", 32'(drop_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int ec;
        int l;
        bit t;
        int lat;
        rst = 1'b1; line_start = 1'b0; ly = '0; tall_spr = 1'b0; sort_done = 1'b0;
        fill(8'd0);
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // 1: single hit at entry 5
        fill(8'd0); mem_y[5] = 8'd50;
        start_line(40, 0, 3, ec);
        chk("t1_expected_cnt", 32'(ec), 1);
        wait_done(200);
        chk("t1_done_after_sortdone", 32'(done_cyc - start_cyc), 4);
        check_line(ec, 3, 1);

        // 2: every entry hits, early exit after ten
        fill(8'd56);
        start_line(40, 0, 0, ec);
        wait_done(200);
        chk("t2_start_cycle", 32'(start_cyc - ls_cyc), 12);
        chk("t2_max_addr", 32'(max_addr), 10);
        check_line(ec, 0, 0);

        // 3: no hits, sorter skipped
        fill(8'd0);
        start_line(100, 0, 5, ec);
        wait_done(200);
        check_line(ec, 5, 1);

        // 4: size and wrap boundaries
        fill(8'd0); mem_y[7] = 8'd12;
        start_line(10, 1, 1, ec);
        wait_done(200); check_line(ec, 1, 1);
        chk("t4_tall_hit", 32'(ec), 1);
        start_line(10, 0, 1, ec);
        wait_done(200); check_line(ec, 1, 1);
        fill(8'd200); mem_y[3] = 8'd20;
        start_line(0, 0, 1, ec);
        wait_done(200); check_line(ec, 1, 1);
        fill(8'd0); mem_y[2] = 8'd49; mem_y[9] = 8'd48; mem_y[30] = 8'd56; mem_y[39] = 8'd53;
        start_line(40, 0, 2, ec);
        chk("t4_edge_cnt", 32'(ec), 3);
        wait_done(200); check_line(ec, 2, 1);

        // random lines
        for (int r = 0; r < 5; r++) begin
            l = $urandom_range(20, 140);
            t = 1'($urandom_range(0, 1));
            lat = $urandom_range(0, 4);
            for (int i = 0; i < NUM; i++) begin
                mem_y[i] = 8'(l + 16 - $urandom_range(0, 40));
                mem_x[i] = 8'($urandom_range(0, 255));
            end
            start_line(l, t, lat, ec);
            wait_done(200);
            check_line(ec, lat, ec < MAXS);
        end

        // 5: line_start ignored during SCAN and SORT
        fill(8'd0); mem_y[5] = 8'd50;
        start_line(40, 0, 20, ec);
        goto(ls_cyc + 5);
        ly = 8'd99; line_start = 1'b1; @(posedge clk); #1; line_start = 1'b0;
        goto(ls_cyc + 45);
        line_start = 1'b1; @(posedge clk); #1; line_start = 1'b0;
        wait_done(200);
        chk("t5_drops", 32'(n_drop), 2);
        check_line(ec, 20, 1);

        // 5b: reset during SORT
        start_line(40, 0, -1, ec);
        goto(ls_cyc + 50);
        chk("t5_busy_in_sort", 32'(busy_out), 1);
        do_reset();

        // 6: sorter never answers
        start_line(40, 0, -1, ec);
`ifdef SORT_TIMEOUT_EN
        wait_done(400);
        chk("t6_timeout_cycles", 32'(done_cyc - start_cyc), TMO);
        chk("t6_err", 32'(err_out), 1);
        chk("t6_valid", 32'(list_valid_out), 1);
        chk("t6_count", 32'(sort_count), 1);
`else
        goto(ls_cyc + 42 + 300);
        chk("t6_still_busy", 32'(busy_out), 1);
        chk("t6_no_done", 32'(done_seen), 0);
        chk("t6_err_tied", 32'(err_out), 0);
`endif
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
        $fatal(1);
    end

endmodule
